// File: rtl/lh_decim_pkg.sv
// Shared types and helpers for the lh_decim_avg accumulate-and-dump decimator.
package lh_decim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int R_DEF    = 14;
  localparam int NMAX_DEF = 16;

  // Limits the requested exponent so the accumulator can never overflow.
  function automatic logic [4:0] clamp_nlog(input logic [4:0] n, input int nmax);
    return (int'(n) > nmax) ? 5'(nmax) : n;
  endfunction

endpackage

// File: rtl/lh_decim_minmax.sv
// Per-window signed min/max tracker; reloads on the first accepted sample of a
// window and publishes the extrema on the dump edge.
module lh_decim_minmax #(
  parameter int R = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [R-1:0] sample,
  input  logic                accept,
  input  logic                first,
  input  logic                dump,
  output logic signed [R-1:0] min_val,
  output logic signed [R-1:0] max_val
);

  logic signed [R-1:0] run_min, run_max;
  logic signed [R-1:0] nxt_min, nxt_max;

  assign nxt_min = (first || (sample < run_min)) ? sample : run_min;
  assign nxt_max = (first || (sample > run_max)) ? sample : run_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_min <= '0;
      run_max <= '0;
      min_val <= '0;
      max_val <= '0;
    end else begin
      if (accept) begin
        run_min <= nxt_min;
        run_max <= nxt_max;
      end
      if (dump) begin
        min_val <= nxt_min;
        max_val <= nxt_max;
      end
    end
  end

endmodule

// File: rtl/lh_decim_avg.sv
// Accumulate-and-dump decimator: averages non-overlapping windows of 2^n_log
// accepted samples. Optional window extrema with LH_DECIM_MINMAX_EN.
module lh_decim_avg
  import lh_decim_pkg::*;
#(
  parameter int R    = R_DEF,
  parameter int NMAX = NMAX_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clr,
  input  logic [4:0]          n_log,
  input  logic signed [R-1:0] in,
  input  logic                in_valid,
  output logic signed [R-1:0] out,
  output logic                out_valid,
  output logic                busy
`ifdef LH_DECIM_MINMAX_EN
  ,
  output logic signed [R-1:0] out_min,
  output logic signed [R-1:0] out_max
`endif
);

  localparam int AW = R + NMAX;

  state_t               state, state_next;
  logic [4:0]           n_l;
  logic [NMAX-1:0]      cnt, lim;
  logic signed [AW-1:0] acc, sum;
  logic                 accept, last, dump;

  assign busy   = (state != IDLE);
  assign accept = busy && en && !clr && in_valid;
  assign lim    = ~({NMAX{1'b1}} << n_l);
  assign last   = (cnt == lim);
  assign dump   = accept && last;
  assign sum    = acc + AW'(in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    // NOTE: non-blocking for every registered signal so all flops sample
    // pre-edge values regardless of block ordering.
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default first, so no path leaves state_next unassigned and no
    // latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = FILL;
      FILL: begin
        if (!en)       state_next = IDLE;
        else if (clr)  state_next = FILL;
        else if (dump) state_next = RUN;
      end
      RUN: begin
        if (!en)      state_next = IDLE;
        else if (clr) state_next = FILL;
      end
      default: state_next = IDLE;
    endcase
  end

  // While idle, n_l tracks n_log so the first window uses the value present on enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      n_l       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (!en || state == IDLE || clr) begin
        acc <= '0;
        cnt <= '0;
        n_l <= clamp_nlog(n_log, NMAX);
      end else if (accept) begin
        if (last) begin
          out       <= R'(sum >>> n_l);
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          n_l       <= clamp_nlog(n_log, NMAX);
        end else begin
          acc <= sum;
          cnt <= cnt + NMAX'(1);
        end
      end
    end
  end

`ifdef LH_DECIM_MINMAX_EN
  logic first;
  assign first = accept && (cnt == '0);

  lh_decim_minmax #(.R(R)) u_minmax (
    .clk     (clk),
    .rst_n   (rst_n),
    .sample  (in),
    .accept  (accept),
    .first   (first),
    .dump    (dump),
    .min_val (out_min),
    .max_val (out_max)
  );
`else
  // Extrema tracking compiled out; averaging path is unchanged.
`endif

endmodule

// File: tb/tb_lh_decim_avg.sv
// Self-checking bench for lh_decim_avg: directed test-plan steps plus random
// traffic against a queue-based window-average reference model.
module tb_lh_decim_avg;

  localparam int R    = 14;
  localparam int NMAX = 16;

  logic                clk = 1'b0;
  logic                rst_n, en, clr, in_valid;
  logic [4:0]          n_log;
  logic signed [R-1:0] in, out;
  logic                out_valid, busy;
`ifdef LH_DECIM_MINMAX_EN
  logic signed [R-1:0] out_min, out_max;
`endif

  always #4 clk = ~clk;

  lh_decim_avg #(.R(R), .NMAX(NMAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .n_log     (n_log),
    .in        (in),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy)
`ifdef LH_DECIM_MINMAX_EN
    ,
    .out_min   (out_min),
    .out_max   (out_max)
`endif
  );

  int n_vec = 0;
  int n_miscmp = 0;

  // Reference model: list of samples in the open window, plus expected outputs.
  bit m_active  = 1'b0;
  int m_nl      = 0;
  int win[$];
  int exp_out   = 0;
  int exp_min   = 0;
  int exp_max   = 0;
  bit exp_valid = 1'b0;

  task automatic check(input string tag, input logic signed [31:0] obs, input int exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_miscmp++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int clampf(input int n);
    return (n > NMAX) ? NMAX : n;
  endfunction

  // Average rounded toward minus infinity, done with plain integer division.
  function automatic int floor_div(input int s, input int sh);
    int d, q;
    d = 1 << sh;
    q = s / d;
    if ((s % d != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_edge(input bit e, input bit c, input int nl, input int x, input bit v);
    int s, mn, mx;
    exp_valid = 1'b0;
    if (!e) begin
      m_active = 1'b0;
      win.delete();
    end else if (!m_active) begin
      m_active = 1'b1;
      win.delete();
      m_nl = clampf(nl);
    end else if (c) begin
      win.delete();
      m_nl = clampf(nl);
    end else if (v) begin
      win.push_back(x);
      if (win.size() == (1 << m_nl)) begin
        s = 0; mn = win[0]; mx = win[0];
        foreach (win[i]) begin
          s += win[i];
          if (win[i] < mn) mn = win[i];
          if (win[i] > mx) mx = win[i];
        end
        exp_out   = floor_div(s, m_nl);
        exp_min   = mn;
        exp_max   = mx;
        exp_valid = 1'b1;
        win.delete();
        m_nl = clampf(nl);
      end
    end
  endtask

  task automatic step(input bit e, input bit c, input int nl, input int x, input bit v);
    @(negedge clk);
    en = e; clr = c; n_log = 5'(nl); in = R'(x); in_valid = v;
    @(posedge clk);
    #1;
    model_edge(e, c, nl, x, v);
    check("out", out, exp_out);
    check("out_valid", out_valid, int'(exp_valid));
    check("busy", busy, int'(m_active));
`ifdef LH_DECIM_MINMAX_EN
    check("out_min", out_min, exp_min);
    check("out_max", out_max, exp_max);
`endif
  endtask

  initial begin
    int samp[4];
    int x;
    samp[0] = 100; samp[1] = 200; samp[2] = 300; samp[3] = 400;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; n_log = 5'd0; in = '0; in_valid = 1'b0;
    #20;
    check("rst_out", out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plan 1: window of 4, repeating 100..400 -> 250 every 4 cycles.
    step(1, 0, 2, 0, 0);
    for (int k = 0; k < 12; k++) begin
      step(1, 0, 2, samp[k % 4], 1);
      if (k % 4 == 3) begin
        check("t1_avg", out, 250);
        check("t1_strobe", out_valid, 1);
      end
    end

    // Plan 2: constant -1 and alternating extremes both average to -1.
    step(1, 1, 3, 0, 0);
    for (int k = 0; k < 8; k++) step(1, 0, 3, -1, 1);
    check("t2_neg1", out, -1);
    for (int k = 0; k < 8; k++) step(1, 0, 3, (k % 2 == 0) ? -8192 : 8191, 1);
    check("t2_alt", out, -1);

    // Plan 3: paused samples, n_log change mid-window deferred.
    step(1, 1, 1, 0, 0);
    for (int k = 0; k < 8; k++) step(1, 0, (k >= 5) ? 4 : 1, 10 * k, (k % 2 == 0));
    for (int k = 0; k < 18; k++) step(1, 0, 4, 50 + k, 1);

    // Plan 4: clr on the final sample suppresses the dump.
    step(1, 1, 2, 0, 0);
    for (int k = 0; k < 3; k++) step(1, 0, 2, 1000, 1);
    step(1, 1, 2, 1000, 1);
    check("t4_nodump", out_valid, 0);
    for (int k = 0; k < 4; k++) step(1, 0, 2, -40 * k, 1);
    check("t4_dump", out_valid, 1);

    // Plan 5: n_log=0 is a one-cycle pipe.
    step(1, 1, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 0, k, 1);
      check("t5_pipe", out, k);
    end

    // Random traffic including clamped exponents, clr and enable drops.
    for (int k = 0; k < 600; k++) begin
      x = int'($urandom_range(0, 16383)) - 8192;
      if ($urandom_range(0, 7) == 0) x = ($urandom_range(0, 1) == 0) ? -8192 : 8191;
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 15) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 4)),
           x,
           ($urandom_range(0, 3) != 0));
    end

    // Plan 6: asynchronous reset mid-window after out=250.
    step(1, 1, 2, 0, 0);
    for (int k = 0; k < 4; k++) step(1, 0, 2, samp[k], 1);
    check("t6_pre", out, 250);
    step(1, 0, 2, 77, 1);
    step(1, 0, 2, 78, 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_out", out, 0);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    m_active = 1'b0; win.delete(); exp_out = 0; exp_valid = 1'b0; exp_min = 0; exp_max = 0;
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 2, 0, 0);
    step(1, 0, 2, 5, 1);
    step(1, 0, 2, -3, 1);
    step(1, 0, 2, 7, 1);
    step(1, 0, 2, 1, 1);
    check("t6_avg", out, 2);
`ifdef LH_DECIM_MINMAX_EN
    check("t6_min", out_min, -3);
    check("t6_max", out_max, 7);
`endif
    step(0, 0, 2, 0, 0);
    check("t6_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/lh_decim_avg.md
# lh_decim_avg

Accumulate-and-dump decimator placed directly downstream of the low/high-pass filter stage. It consumes the filtered sample stream at the full clock rate, averages non-overlapping windows of 2^n_log accepted samples, and emits one averaged sample per window with a single-cycle strobe. Its output feeds slow consumers such as register readback, scope decimation and the PID error path.

## Interface
- R, 14, sample width (signed) of in/out
- NMAX, 16, maximum decimation exponent; accumulator is R+NMAX bits
- clk  in  1  system clock (125 MHz)
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- en  in  1  run enable; low forces IDLE
- clr  in  1  synchronous window restart, one-cycle pulse
- n_log  in  5  decimation exponent; window = 2^n_log samples
- in  in  R  signed filtered sample
- in_valid  in  1  sample qualifier; tied high when the source runs every cycle
- out  out  R  signed window average, held between dumps
- out_valid  out  1  one-cycle strobe per completed window
- busy  out  1  high in states FILL and RUN
- out_min, out_max  out  R each  window extrema, only with LH_DECIM_MINMAX_EN

## Operation
- States:
  - IDLE: en=0.
  - FILL: first window after enable or clr; no valid output yet.
  - RUN: steady state.
- Transitions:
  - IDLE→FILL when en=1.
  - FILL→RUN on the first dump.
  - Any→IDLE when en=0.
  - FILL/RUN→FILL on clr.
- Window start: n_log is latched as n_l = min(n_log, NMAX). Changes to n_log mid-window are ignored until the next window starts.
- Accepted sample: in_valid=1 in FILL/RUN with clr=0. The sample is added to acc and the counter cnt increments. Cycles with in_valid=0 pause the window.
- Dump: on the accepted sample where cnt = 2^n_l − 1:
  - out ← (acc + in) >>> n_l, i.e. arithmetic shift, truncation toward −∞.
  - acc ← 0, cnt ← 0, out_valid ← 1 on the next cycle.
  - Back-to-back windows have no gap sample.
- n_l=0: every accepted sample dumps, so out = in delayed by one cycle.
- Arithmetic: acc is signed R+NMAX bits and cannot overflow by construction. The shifted result always fits in R bits, so no saturation is needed. out takes acc bits [R-1:0] after the shift.
- clr in the same cycle as a would-be dump: clr wins. There is no dump, the sample is discarded, and acc, cnt and n_l restart.
- en=0 mid-window: partial window discarded. out, out_min and out_max are retained.

## Timing
- Reset values: out=0, out_valid=0, busy=0, out_min=0, out_max=0, state=IDLE, acc=0, cnt=0.
- Latency: out and out_valid update on the clock edge after the edge that accepts the final sample of a window.
- out_valid is high for exactly one cycle per window. The minimum period is 2^n_l cycles when in_valid is continuous.
- busy rises one cycle after en rises and falls one cycle after en falls.
- Asserting rst_n low mid-window clears everything immediately. The first window after release starts in FILL once en=1.

## Configuration
- LH_DECIM_MINMAX_EN defined:
  - Tracks the signed min and max of the accepted samples in each window.
  - out_min and out_max update on the same edge as out, with out_valid.
  - The tracker reloads from the first sample of each window.
- Undefined:
  - out_min and out_max ports are absent.
  - No tracker logic is instantiated.
  - All other behaviour is identical.

## Structure
- Shared package lh_decim_pkg:
  - State enum (IDLE, FILL, RUN).
  - Localparam for the default NMAX.
  - Function clamping n_log to NMAX.
- Sub-module lh_decim_minmax, instantiated under LH_DECIM_MINMAX_EN:
  - Inputs: clk, rst_n, sample, accept, first, dump.
  - Outputs: registered min and max.
- Top level holds the FSM, counter, accumulator and output registers. Target size is about 200 lines.

## Test plan
1. R=14, n_log=2, in_valid=1, in=100,200,300,400 repeating:
   - out=250 with out_valid one cycle after the 4th sample.
   - Strobes every 4 cycles.
2. n_log=3, in=−1 constant:
   - out=−1, confirming the shift truncates toward −∞.
   - Then in alternating −8192/+8191 gives out=−1.
3. n_log=1, in_valid toggling 1,0,1,0:
   - Dump occurs after 2 accepted samples, 4 cycles apart.
   - Changing n_log to 4 mid-window takes effect only from the next window.
4. clr pulsed coincident with the last sample of an n_log=2 window:
   - No out_valid.
   - out keeps its previous value.
   - Next dump occurs after 4 new samples.
5. n_log=0 with in ramping 0,1,2:
   - out follows in with 1-cycle latency.
   - out_valid is high every cycle.
6. rst_n asserted mid-window with out=250:
   - out=0, out_valid=0 and busy=0 immediately, asynchronously.
   - With LH_DECIM_MINMAX_EN, window 5,−3,7,1 at n_log=2 gives out_min=−3, out_max=7 and out=2.
